scrf_loader: RTL
================

Name: scrf_loader

Overview:
- Run-time loadable replacement for the hard-wired system config register file.
- Accepts addressed 32-bit config writes from the host/DMA into a shadow bank.
- On a commit request, waits for the PE array to go idle, then atomically copies shadow to active.
- Drives the packed config fields consumed by DFSM, SSP, quad/single buffers, PEs and I/O ports.

Parameters:
- N_WORDS, 34, number of 32-bit config words (addresses 0..33)
- ADDR_W, 6, config write/read address width
- N_IPORT, 12, number of input-port config fields
- N_OPORT, 2, number of output-port config fields

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr_valid  in  1  write request
- cfg_wr_ready  out  1  write accepted when valid&&ready
- cfg_wr_addr  in  ADDR_W  config word address
- cfg_wr_data  in  32  config word data
- commit_req  in  1  single-cycle pulse: request shadow->active copy
- array_idle  in  1  PE array/dataflow FSM idle; commit allowed only when high
- cfg_rd_addr  in  ADDR_W  readback address (active bank)
- cfg_rd_data  out  32  readback data, 1-cycle latency
- cfg_updated  out  1  one-cycle pulse when active bank changes
- addr_err  out  1  sticky: a write targeted addr >= N_WORDS
- busy  out  1  commit pending or in progress
- dfsm_config  out  23  active field
- ssp_config  out  20  active field
- quabuf_config  out  38  active field
- singbuf_config  out  26  active field
- mode_conv_mm, isac, isrelu, isbn  out  1 each  active flags
- pe_config  out  6  bits [2:0] = pe_config_1_1..1_3, [5:3] = pe_config_2_1..2_3
- iport_configbits  out  [N_IPORT][56]  active input-port fields
- oport_configbits  out  [N_OPORT][56]  active output-port fields

Behaviour:
- Word map, all fields LSB-aligned:
  - w0 dfsm[22:0]; w1 ssp[19:0]; w2/w3 quabuf low32/high6; w4 singbuf[25:0]
  - w5 flags: bit0 mode_conv_mm, bit1 isac, bit2 isrelu, bit3 isbn, bits9:4 pe_config
  - w(6+2k)/w(7+2k) iport k low32/high24
  - w30/w31 oport0; w32/w33 oport1
  - Unused high bits are written to storage but ignored on output; readback returns the stored word.
- Reset:
  - Shadow and active banks both load SCRF_DEFAULT words: dfsm=524387, ssp=12, quabuf=206695305224, singbuf=4104, flags: mode_conv_mm=0 and isac=isrelu=isbn=1 with pe_config=6'h3F, iport k per package table, oport=0.
  - FSM=IDLE; cfg_wr_ready=1; cfg_updated=0; addr_err=0; busy=0; cfg_rd_data=0.
- FSM states IDLE, WAIT_IDLE, COMMIT:
  - IDLE: cfg_wr_ready=1. A commit_req moves to WAIT_IDLE. A write in the same cycle as commit_req is applied to shadow and is included in that commit.
  - WAIT_IDLE: cfg_wr_ready=0, busy=1. Goes to COMMIT on the first cycle array_idle=1 is sampled. Stays indefinitely otherwise.
  - COMMIT: busy=1. Active<=shadow in one cycle. cfg_updated=1 in the following cycle. addr_err cleared. Returns to IDLE.
  - commit_req while not IDLE is ignored (no queuing).
- Latency:
  - commit_req at edge t with array_idle=1 gives new outputs visible after edge t+2; cfg_updated is high in cycle t+2..t+3.
  - Write to active-readback effect requires a commit.
- Out-of-range address (>=N_WORDS): handshake completes, data dropped, addr_err set (sticky until the next commit).
- Readback: cfg_rd_data registered from the active bank; out-of-range reads return 0.
- Async reset mid-commit: all state returns to defaults immediately; the partial commit is discarded.

Decomposition:
- scrf_pkg holds:
  - N_WORDS and the field widths
  - word-index localparams (W_DFSM, W_SSP, W_QUABUF_LO, ..., W_IPORT_BASE, W_OPORT_BASE)
  - SCRF_DEFAULT word array
  - FSM state enum
- One sub-module, scrf_word_bank: dual-bank (shadow/active) 32-bit register array with a write port, a commit strobe and a registered read port.
- scrf_loader wraps it with the FSM and the field unpacking.

Test Plan:
- Reset, then read w0..w5 -> 524387, 12, quabuf low/high words, 4104, flags 0x3FE; dfsm_config=524387, isrelu=1.
- Write w1=0xABCDE, no commit -> ssp_config stays 12. Commit with array_idle=1 -> ssp_config=0xABCDE exactly 2 cycles after commit_req; cfg_updated is a 1-cycle pulse.
- Hold array_idle=0 for 10 cycles after commit_req -> cfg_wr_ready=0, busy=1, outputs unchanged. Raise array_idle -> commit completes 2 cycles later.
- Write to addr 40 -> ready handshake completes, addr_err=1, readback of every word unchanged. Next commit -> addr_err=0.
- Same-cycle write w6=0x1234_5678 and commit_req -> iport_configbits[0][31:0]=0x12345678 after the commit.
- Assert rst_n=0 during WAIT_IDLE after writing w0=0 -> dfsm_config=524387, busy=0, FSM IDLE, shadow restored to defaults.

Source files
------------

// File: rtl/scrf_pkg.sv
// scrf_pkg: shared sizes, word map, reset defaults and FSM encoding for the loadable config register file.
package scrf_pkg;
    localparam int N_WORDS = 34;
    localparam int ADDR_W = 6;
    localparam int N_IPORT = 12;
    localparam int N_OPORT = 2;
    localparam int DFSM_W = 23;
    localparam int SSP_W = 20;
    localparam int QUABUF_W = 38;
    localparam int SINGBUF_W = 26;
    localparam int PE_W = 6;
    localparam int PORT_W = 56;
    localparam int W_DFSM = 0;
    localparam int W_SSP = 1;
    localparam int W_QUABUF_LO = 2;
    localparam int W_QUABUF_HI = 3;
    localparam int W_SINGBUF = 4;
    localparam int W_FLAGS = 5;
    localparam int W_IPORT_BASE = 6;
    localparam int W_OPORT_BASE = 30;
    localparam logic [ADDR_W-1:0] N_WORDS_A = ADDR_W'(N_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT_IDLE, COMMIT} state_t;
    typedef logic [N_WORDS-1:0][31:0] bank_t;
    // Input port k resets to low word 0x0001_0000+k, high word k; output ports reset to zero.
    function automatic bank_t build_default();
        bank_t b;
        b = '0;
        b[W_DFSM] = 32'd524387;
        b[W_SSP] = 32'd12;
        b[W_QUABUF_LO] = 32'h2000_1008;
        b[W_QUABUF_HI] = 32'h0000_0030;
        b[W_SINGBUF] = 32'd4104;
        b[W_FLAGS] = 32'h0000_03FE;
        for (int k = 0; k < N_IPORT; k++) begin
            b[W_IPORT_BASE+2*k] = 32'h0001_0000 + 32'(k);
            b[W_IPORT_BASE+2*k+1] = 32'(k);
        end
        return b;
    endfunction
    localparam bank_t SCRF_DEFAULT = build_default();
endpackage

// File: rtl/scrf_word_bank.sv
// scrf_word_bank: shadow/active 32-bit word banks with a write port, a commit copy strobe and a registered readback.
module scrf_word_bank
    import scrf_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [31:0]               wr_data,
    input  logic                      commit,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [31:0]               rd_data,
    output logic [N_WORDS-1:0][31:0]  active
);
    bank_t shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= SCRF_DEFAULT;
            active <= SCRF_DEFAULT;
            rd_data <= '0;
        end else begin
            if (wr_en && wr_addr < N_WORDS_A) shadow[wr_addr] <= wr_data;
            if (commit) active <= shadow;
            rd_data <= (rd_addr < N_WORDS_A) ? active[rd_addr] : '0;
        end
    end
endmodule

// File: rtl/scrf_loader.sv
// scrf_loader: host-loadable config register file; commits shadow to active once the PE array is idle
// and unpacks the active words into the per-block config fields.
module scrf_loader
    import scrf_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_wr_valid,
    output logic                           cfg_wr_ready,
    input  logic [ADDR_W-1:0]              cfg_wr_addr,
    input  logic [31:0]                    cfg_wr_data,
    input  logic                           commit_req,
    input  logic                           array_idle,
    input  logic [ADDR_W-1:0]              cfg_rd_addr,
    output logic [31:0]                    cfg_rd_data,
    output logic                           cfg_updated,
    output logic                           addr_err,
    output logic                           busy,
    output logic [DFSM_W-1:0]              dfsm_config,
    output logic [SSP_W-1:0]               ssp_config,
    output logic [QUABUF_W-1:0]            quabuf_config,
    output logic [SINGBUF_W-1:0]           singbuf_config,
    output logic                           mode_conv_mm,
    output logic                           isac,
    output logic                           isrelu,
    output logic                           isbn,
    output logic [PE_W-1:0]                pe_config,
    output logic [N_IPORT-1:0][PORT_W-1:0] iport_configbits,
    output logic [N_OPORT-1:0][PORT_W-1:0] oport_configbits
);
    state_t state, next_state;
    logic accept, commit;
    bank_t active;
    logic unused_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = (state == IDLE && commit_req) ? WAIT_IDLE :
                     (state == WAIT_IDLE && array_idle) ? COMMIT :
                     (state == COMMIT) ? IDLE : state;
    end

    // Writes are held off for the whole commit window so the copy is atomic.
    always_comb begin
        cfg_wr_ready = state == IDLE;
        busy = state != IDLE;
        commit = state == COMMIT;
    end

    assign accept = cfg_wr_valid && cfg_wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_updated <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            cfg_updated <= commit;
            addr_err <= commit ? 1'b0 : (accept && cfg_wr_addr >= N_WORDS_A) ? 1'b1 : addr_err;
        end
    end

    scrf_word_bank u_bank (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(accept),
        .wr_addr(cfg_wr_addr),
        .wr_data(cfg_wr_data),
        .commit(commit),
        .rd_addr(cfg_rd_addr),
        .rd_data(cfg_rd_data),
        .active(active)
    );

    assign dfsm_config = active[W_DFSM][DFSM_W-1:0];
    assign ssp_config = active[W_SSP][SSP_W-1:0];
    assign quabuf_config = {active[W_QUABUF_HI][QUABUF_W-33:0], active[W_QUABUF_LO]};
    assign singbuf_config = active[W_SINGBUF][SINGBUF_W-1:0];
    assign mode_conv_mm = active[W_FLAGS][0];
    assign isac = active[W_FLAGS][1];
    assign isrelu = active[W_FLAGS][2];
    assign isbn = active[W_FLAGS][3];
    assign pe_config = active[W_FLAGS][4+:PE_W];

    for (genvar k = 0; k < N_IPORT; k++) begin : g_iport
        assign iport_configbits[k] = {active[W_IPORT_BASE+2*k+1][PORT_W-33:0], active[W_IPORT_BASE+2*k]};
    end
    for (genvar k = 0; k < N_OPORT; k++) begin : g_oport
        assign oport_configbits[k] = {active[W_OPORT_BASE+2*k+1][PORT_W-33:0], active[W_OPORT_BASE+2*k]};
    end

    // Stored high bits beyond each field width are readback-only.
    assign unused_bits = ^active;
endmodule
